// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch control from later stages, instruction memory
// port, IF/ID pipeline register outputs and status counters.
interface fetch_stage_if;
  logic        load_hazard_i;
  logic        branch_stall_i;
  logic        branch_flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] imem_addr_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;
  logic [15:0] stall_count_o;

  modport slave (
    input  load_hazard_i, branch_stall_i, branch_flush_i, branch_taken_i,
           branch_target_i, halt_i, imem_rdata_i,
    output imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
           halted_o, misalign_o, fetch_count_o, stall_count_o
  );

  modport master (
    output load_hazard_i, branch_stall_i, branch_flush_i, branch_taken_i,
           branch_target_i, halt_i, imem_rdata_i,
    input  imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
           halted_o, misalign_o, fetch_count_o, stall_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/BR_WAIT/HALT control FSM with fetch and stall statistics.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic        halted_q;
    logic        misalign_q;
    logic [31:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    logic [31:0] pc4_d;
    logic [15:0] stall_cnt_d;
    logic [31:0] target_d;

    assign pc4_d       = pc_q + 32'd4;
    assign stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 16'd1;
    assign target_d    = {bus.branch_target_i[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (state_q != HALT) begin
            // Priority: halt > load hazard > branch resolution > branch stall > fetch
            if (bus.halt_i) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
                instr_q  <= '0;
                pc4_q    <= '0;
                valid_q  <= 1'b0;
            end else if (bus.load_hazard_i) begin
                stall_cnt_q <= stall_cnt_d;
            end else if (state_q == BR_WAIT) begin
                if (bus.branch_flush_i) begin
                    state_q <= RUN;
                    instr_q <= '0;
                    pc4_q   <= '0;
                    valid_q <= 1'b0;
                    if (bus.branch_taken_i) begin
                        pc_q <= target_d;
                        if (bus.branch_target_i[1:0] != 2'b00) misalign_q <= 1'b1;
                    end
                end else begin
                    stall_cnt_q <= stall_cnt_d;
                end
            end else if (bus.branch_stall_i) begin
                state_q     <= BR_WAIT;
                stall_cnt_q <= stall_cnt_d;
            end else begin
                instr_q     <= bus.imem_rdata_i;
                pc4_q       <= pc4_d;
                valid_q     <= 1'b1;
                pc_q        <= pc4_d;
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign bus.imem_addr_o    = pc_q;
    assign bus.if_id_instr_o  = instr_q;
    assign bus.if_id_pc4_o    = pc4_q;
    assign bus.if_id_valid_o  = valid_q;
    assign bus.halted_o       = halted_q;
    assign bus.misalign_o     = misalign_q;
    assign bus.fetch_count_o  = fetch_cnt_q;
    assign bus.stall_count_o  = stall_cnt_q;

endmodule
